// File: rtl/uart_fifo_gen.sv
// uart_fifo_gen: parametrised first-word-fall-through FIFO for the UART
// transmit and receive paths. Register-array storage, synchronous flush,
// threshold flags and sticky overrun/underrun error flags.
module uart_fifo_gen #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int PTR_W    = 4,
    parameter int CNT_W    = 5,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic             overrun,
    output logic             underrun
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] bottom;
    logic             do_push;
    logic             do_pop;
    logic             push_err;
    logic             pop_err;

    // Accept/reject decisions; a pop frees the slot a same-cycle push needs when full
    always_comb begin
        do_pop   = pop && (count != '0);
        do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);
        push_err = !flush && push && !do_push;
        pop_err  = !flush && pop && !do_pop;
    end

    // Pointers, occupancy and sticky error flags; a new error outranks clr_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top      <= '0;
            bottom   <= '0;
            count    <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (flush) begin
                top    <= '0;
                bottom <= '0;
                count  <= '0;
            end else begin
                if (do_push) top <= top + PTR_W'(1);
                if (do_pop) bottom <= bottom + PTR_W'(1);
                if (do_push && !do_pop) count <= count + CNT_W'(1);
                else if (do_pop && !do_push) count <= count - CNT_W'(1);
            end
            overrun  <= (overrun && !clr_err) || push_err;
            underrun <= (underrun && !clr_err) || pop_err;
        end
    end

    // Storage write; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (!flush && do_push) mem[top] <= data_in;
    end

    // Head word and status flags decoded from registered state
    always_comb begin
        data_out     = mem[bottom];
        empty        = (count == '0);
        full         = (count == CNT_W'(DEPTH));
        almost_full  = (count >= CNT_W'(AF_LEVEL));
        almost_empty = (count <= CNT_W'(AE_LEVEL));
    end

endmodule

// File: tb/tb_uart_fifo_gen.sv
// Bench for uart_fifo_gen: two instances (8x16 default and 12x64), a
// queue-based reference model per instance checked on every falling edge,
// plus directed literal expectations from the test plan.
module tb_uart_fifo_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic        a_push = 1'b0, a_pop = 1'b0, a_flush = 1'b0, a_clr = 1'b0;
    logic [7:0]  a_din = '0;
    logic [7:0]  a_dout;
    logic [4:0]  a_count;
    logic        a_empty, a_full, a_ae, a_af, a_ov, a_un;

    logic        b_push = 1'b0, b_pop = 1'b0, b_flush = 1'b0, b_clr = 1'b0;
    logic [11:0] b_din = '0;
    logic [11:0] b_dout;
    logic [6:0]  b_count;
    logic        b_empty, b_full, b_ae, b_af, b_ov, b_un;

    int tests = 0;
    int fails = 0;

    logic [7:0]  qa[$];
    logic [11:0] qb[$];
    bit ova = 0, una = 0, ovb = 0, unb = 0;
    bit rd, wr;

    always #5 clk = ~clk;

    uart_fifo_gen #(.WIDTH(8), .DEPTH(16), .PTR_W(4), .CNT_W(5),
                    .AF_LEVEL(14), .AE_LEVEL(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .push(a_push), .pop(a_pop), .flush(a_flush),
        .clr_err(a_clr), .data_in(a_din), .data_out(a_dout), .count(a_count),
        .empty(a_empty), .full(a_full), .almost_empty(a_ae), .almost_full(a_af),
        .overrun(a_ov), .underrun(a_un)
    );

    uart_fifo_gen #(.WIDTH(12), .DEPTH(64), .PTR_W(6), .CNT_W(7),
                    .AF_LEVEL(60), .AE_LEVEL(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .push(b_push), .pop(b_pop), .flush(b_flush),
        .clr_err(b_clr), .data_in(b_din), .data_out(b_dout), .count(b_count),
        .empty(b_empty), .full(b_full), .almost_empty(b_ae), .almost_full(b_af),
        .overrun(b_ov), .underrun(b_un)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic sa(input logic pu, input logic po, input logic fl,
                      input logic ce, input logic [7:0] d);
        a_push = pu; a_pop = po; a_flush = fl; a_clr = ce; a_din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic sb(input logic pu, input logic po, input logic fl,
                      input logic ce, input logic [11:0] d);
        b_push = pu; b_pop = po; b_flush = fl; b_clr = ce; b_din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            // reference model: queues updated by the FIFO rules
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    qa.delete(); qb.delete();
                    ova = 0; una = 0; ovb = 0; unb = 0;
                end else begin
                    if (a_flush) begin
                        qa.delete();
                        ova = ova && !a_clr;
                        una = una && !a_clr;
                    end else begin
                        rd = a_pop && (qa.size() > 0);
                        wr = a_push && (qa.size() < 16 || rd);
                        ova = (ova && !a_clr) || (a_push && !wr);
                        una = (una && !a_clr) || (a_pop && !rd);
                        if (rd) void'(qa.pop_front());
                        if (wr) qa.push_back(a_din);
                    end
                    if (b_flush) begin
                        qb.delete();
                        ovb = ovb && !b_clr;
                        unb = unb && !b_clr;
                    end else begin
                        rd = b_pop && (qb.size() > 0);
                        wr = b_push && (qb.size() < 64 || rd);
                        ovb = (ovb && !b_clr) || (b_push && !wr);
                        unb = (unb && !b_clr) || (b_pop && !rd);
                        if (rd) void'(qb.pop_front());
                        if (wr) qb.push_back(b_din);
                    end
                end
            end
            // per-cycle comparison against the model
            forever begin
                @(negedge clk);
                chk("a_count", int'(a_count), qa.size());
                chk("a_empty", int'(a_empty), int'(qa.size() == 0));
                chk("a_full",  int'(a_full),  int'(qa.size() == 16));
                chk("a_ae",    int'(a_ae),    int'(qa.size() <= 2));
                chk("a_af",    int'(a_af),    int'(qa.size() >= 14));
                chk("a_ov",    int'(a_ov),    int'(ova));
                chk("a_un",    int'(a_un),    int'(una));
                if (qa.size() > 0) chk("a_data", int'(a_dout), int'(qa[0]));
                chk("b_count", int'(b_count), qb.size());
                chk("b_empty", int'(b_empty), int'(qb.size() == 0));
                chk("b_full",  int'(b_full),  int'(qb.size() == 64));
                chk("b_ae",    int'(b_ae),    int'(qb.size() <= 4));
                chk("b_af",    int'(b_af),    int'(qb.size() >= 60));
                chk("b_ov",    int'(b_ov),    int'(ovb));
                chk("b_un",    int'(b_un),    int'(unb));
                if (qb.size() > 0) chk("b_data", int'(b_dout), int'(qb[0]));
            end
        join_none

        // reset
        #1 rst_n = 1'b0;
        #20;
        chk("rst_count", int'(a_count), 0);
        chk("rst_empty", int'(a_empty), 1);
        chk("rst_full",  int'(a_full), 0);
        chk("rst_ae",    int'(a_ae), 1);
        chk("rst_af",    int'(a_af), 0);
        chk("rst_ov",    int'(a_ov), 0);
        chk("rst_un",    int'(a_un), 0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // fill with 0x11..0x20
        for (int i = 0; i < 16; i++) begin
            sa(1, 0, 0, 0, 8'(8'h11 + i));
            if (i == 12) chk("fill_af13", int'(a_af), 0);
            if (i == 13) chk("fill_af14", int'(a_af), 1);
        end
        chk("fill_full",  int'(a_full), 1);
        chk("fill_count", int'(a_count), 16);
        chk("fill_head",  int'(a_dout), 8'h11);

        // overrun on full, then drain in order
        sa(1, 0, 0, 0, 8'hAA);
        chk("ovr_count", int'(a_count), 16);
        chk("ovr_flag",  int'(a_ov), 1);
        for (int i = 0; i < 16; i++) begin
            chk("drain_read", int'(a_dout), 8'h11 + i);
            sa(0, 1, 0, 0, 8'h00);
        end
        chk("drain_empty", int'(a_empty), 1);

        // push+pop on empty
        sa(1, 1, 0, 0, 8'h5C);
        chk("pp_count", int'(a_count), 1);
        chk("pp_head",  int'(a_dout), 8'h5C);
        chk("pp_un",    int'(a_un), 1);
        sa(0, 0, 0, 1, 8'h00);
        chk("clr_ov", int'(a_ov), 0);
        chk("clr_un", int'(a_un), 0);

        // refill, then sustained push+pop across pointer wrap
        for (int i = 0; i < 15; i++) sa(1, 0, 0, 0, 8'(8'h30 + i));
        chk("refill_full", int'(a_full), 1);
        for (int i = 0; i < 20; i++) begin
            chk("wrap_read", int'(a_dout),
                (i == 0) ? 8'h5C : (i < 16) ? (8'h30 + i - 1) : (8'h60 + i - 16));
            sa(1, 1, 0, 0, 8'(8'h60 + i));
            chk("wrap_count", int'(a_count), 16);
            chk("wrap_ov",    int'(a_ov), 0);
        end
        chk("wrap_head", int'(a_dout), 8'h64);

        // flush with 9 entries and a pending push; error flags kept
        sa(1, 0, 0, 0, 8'hEE);
        chk("ovr2_flag", int'(a_ov), 1);
        for (int i = 0; i < 7; i++) sa(0, 1, 0, 0, 8'h00);
        chk("pre_flush_count", int'(a_count), 9);
        sa(1, 0, 1, 0, 8'hBB);
        chk("flush_count", int'(a_count), 0);
        chk("flush_empty", int'(a_empty), 1);
        chk("flush_ov",    int'(a_ov), 1);
        chk("flush_un",    int'(a_un), 0);
        // new error wins over clr_err in the same cycle
        sa(0, 1, 0, 1, 8'h00);
        chk("clrpri_ov", int'(a_ov), 0);
        chk("clrpri_un", int'(a_un), 1);
        sa(0, 0, 0, 1, 8'h00);
        chk("clr2_un", int'(a_un), 0);

        // asynchronous reset mid-stream at count 7
        for (int i = 0; i < 7; i++) sa(1, 0, 0, 0, 8'(8'h40 + i));
        sa(0, 0, 0, 0, 8'h00);
        chk("pre_rst_count", int'(a_count), 7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", int'(a_count), 0);
        chk("arst_empty", int'(a_empty), 1);
        chk("arst_ae",    int'(a_ae), 1);
        chk("arst_full",  int'(a_full), 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        sa(1, 0, 0, 0, 8'h99);
        chk("post_rst_head",  int'(a_dout), 8'h99);
        chk("post_rst_count", int'(a_count), 1);
        sa(0, 0, 0, 0, 8'h00);

        // wide/deep instance: thresholds at 60 and 4
        for (int i = 0; i < 64; i++) begin
            sb(1, 0, 0, 0, 12'(12'h100 + i));
            if (i == 3)  chk("b_ae_at4",  int'(b_ae), 1);
            if (i == 4)  chk("b_ae_at5",  int'(b_ae), 0);
            if (i == 58) chk("b_af_at59", int'(b_af), 0);
            if (i == 59) chk("b_af_at60", int'(b_af), 1);
        end
        chk("b_fill_full",  int'(b_full), 1);
        chk("b_fill_count", int'(b_count), 64);
        chk("b_fill_head",  int'(b_dout), 12'h100);
        sb(1, 0, 0, 0, 12'hFFF);
        chk("b_ovr_flag",  int'(b_ov), 1);
        chk("b_ovr_count", int'(b_count), 64);
        for (int i = 0; i < 64; i++) begin
            chk("b_drain_read", int'(b_dout), 12'h100 + i);
            sb(0, 1, 0, 0, 12'h000);
            if (i == 3)  chk("b_af_dn60", int'(b_af), 1);
            if (i == 4)  chk("b_af_dn59", int'(b_af), 0);
            if (i == 58) chk("b_ae_dn5",  int'(b_ae), 0);
            if (i == 59) chk("b_ae_dn4",  int'(b_ae), 1);
        end
        chk("b_drain_empty", int'(b_empty), 1);
        sb(0, 0, 0, 0, 12'h000);

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
